// File: rtl/countdown_timer_hms.sv
// Loadable hh:mm:ss countdown timer with borrow ripple, a one-cycle done pulse and a sticky
// expired flag. All state, including the outputs, is registered on the rising clock edge.
module countdown_timer_hms #(
    parameter int unsigned MAX_HOURS = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       clear,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] hours_in,
    input  logic [5:0] minutes_in,
    input  logic [5:0] seconds_in,
    output logic [3:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam logic [3:0] MaxHours = 4'(MAX_HOURS);
    localparam logic [5:0] MaxMinSec = 6'd59;

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

    state_e     state_q, state_d;
    logic [3:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       done_q, done_d;

    logic [3:0] hours_dec;
    logic [5:0] minutes_dec, seconds_dec;
    logic       count_nz;

    assign count_nz = |{hours_q, minutes_q, seconds_q};

    // One-second borrow ripple; only used from RUN, which is never entered at zero.
    always_comb begin
        hours_dec   = hours_q;
        minutes_dec = minutes_q;
        seconds_dec = seconds_q;
        if (seconds_q != 6'd0) begin
            seconds_dec = seconds_q - 6'd1;
        end else if (minutes_q != 6'd0) begin
            seconds_dec = MaxMinSec;
            minutes_dec = minutes_q - 6'd1;
        end else if (hours_q != 4'd0) begin
            seconds_dec = MaxMinSec;
            minutes_dec = MaxMinSec;
            hours_dec   = hours_q - 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        done_d    = 1'b0;

        if (clear) begin
            state_d   = StIdle;
            hours_d   = 4'd0;
            minutes_d = 6'd0;
            seconds_d = 6'd0;
        end else if (state_q == StRun) begin
            // load and start are meaningless while running; only tick and pause act here.
            if (tick) begin
                hours_d   = hours_dec;
                minutes_d = minutes_dec;
                seconds_d = seconds_dec;
            end
            if (tick && !(|{hours_dec, minutes_dec, seconds_dec})) begin
                state_d = StExpired;
                done_d  = 1'b1;
            end else if (pause) begin
                state_d = StPaused;
            end
        end else if (load) begin
            state_d   = StIdle;
            hours_d   = (hours_in > MaxHours) ? MaxHours : hours_in;
            minutes_d = (minutes_in > MaxMinSec) ? MaxMinSec : minutes_in;
            seconds_d = (seconds_in > MaxMinSec) ? MaxMinSec : seconds_in;
        end else if (start && state_q != StExpired && count_nz) begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            hours_q   <= 4'd0;
            minutes_q <= 6'd0;
            seconds_q <= 6'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            done_q    <= done_d;
        end
    end

    assign hours   = hours_q;
    assign minutes = minutes_q;
    assign seconds = seconds_q;
    assign running = (state_q == StRun);
    assign expired = (state_q == StExpired);
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer_hms.sv
// Directed bench for countdown_timer_hms: the driver queues the expected post-edge outputs
// for every cycle it drives, and an independent monitor pops and compares them.
module tb_countdown_timer_hms;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] hours_in = 4'd0;
    logic [5:0] minutes_in = 6'd0, seconds_in = 6'd0;
    logic [3:0] hours;
    logic [5:0] minutes, seconds;
    logic       running, expired, done;

    countdown_timer_hms #(.MAX_HOURS(12)) dut (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .clear      (clear),
        .load       (load),
        .start      (start),
        .pause      (pause),
        .hours_in   (hours_in),
        .minutes_in (minutes_in),
        .seconds_in (seconds_in),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       run;
        logic       exp;
        logic       dn;
    } exp_t;

    // Control bit masks: {reset, clear, load, start, pause, tick}
    localparam logic [5:0] N  = 6'b000000;
    localparam logic [5:0] TK = 6'b000001;
    localparam logic [5:0] PS = 6'b000010;
    localparam logic [5:0] ST = 6'b000100;
    localparam logic [5:0] LD = 6'b001000;
    localparam logic [5:0] CL = 6'b010000;
    localparam logic [5:0] RS = 6'b100000;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    function automatic exp_t mk(input int h, input int m, input int s,
                                input bit run, input bit ex, input bit dn);
        exp_t e;
        e.h   = 4'(h);
        e.m   = 6'(m);
        e.s   = 6'(s);
        e.run = run;
        e.exp = ex;
        e.dn  = dn;
        return e;
    endfunction

    task automatic cyc(input logic [5:0] ctl, input int hi, input int mi, input int si,
                       input exp_t e, input string nm);
        {reset, clear, load, start, pause, tick} = ctl;
        hours_in   = 4'(hi);
        minutes_in = 6'(mi);
        seconds_in = 6'(si);
        @(posedge clock);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clock);
    endtask

    // Monitor: the DUT presents a new registered output set after every edge.
    exp_t  got, want;
    string nm_m;
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm_m = name_q.pop_front();
            got  = {hours, minutes, seconds, running, expired, done};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s: got %0d:%0d:%0d run=%b exp=%b done=%b, want %0d:%0d:%0d run=%b exp=%b done=%b",
                         nm_m, got.h, got.m, got.s, got.run, got.exp, got.dn,
                         want.h, want.m, want.s, want.run, want.exp, want.dn);
            end
        end
    end

    initial begin
        int rem;
        @(negedge clock);
        cyc(RS, 0, 0, 0, mk(0, 0, 0, 0, 0, 0), "reset");

        // 0:01:05 down to zero
        cyc(LD, 0, 1, 5, mk(0, 1, 5, 0, 0, 0), "load_0_01_05");
        cyc(ST, 0, 0, 0, mk(0, 1, 5, 1, 0, 0), "start_65");
        for (int i = 1; i <= 65; i++) begin
            rem = 65 - i;
            cyc(TK, 0, 0, 0, mk(0, rem / 60, rem % 60, rem != 0, rem == 0, rem == 0), "count65");
        end
        cyc(N, 0, 0, 0, mk(0, 0, 0, 0, 1, 0), "done_drops");
        cyc(TK, 0, 0, 0, mk(0, 0, 0, 0, 1, 0), "tick_in_expired");
        cyc(ST, 0, 0, 0, mk(0, 0, 0, 0, 1, 0), "start_in_expired");

        // Double borrow and clamping
        cyc(LD, 1, 0, 0, mk(1, 0, 0, 0, 0, 0), "load_1h_clears_exp");
        cyc(ST, 0, 0, 0, mk(1, 0, 0, 1, 0, 0), "start_1h");
        cyc(TK, 0, 0, 0, mk(0, 59, 59, 1, 0, 0), "double_borrow");
        cyc(PS, 0, 0, 0, mk(0, 59, 59, 0, 0, 0), "pause");
        cyc(LD, 15, 63, 60, mk(12, 59, 59, 0, 0, 0), "clamp");

        // Pause coinciding with a tick
        cyc(LD, 0, 0, 10, mk(0, 0, 10, 0, 0, 0), "load_10s");
        cyc(ST, 0, 0, 0, mk(0, 0, 10, 1, 0, 0), "start_10s");
        for (int i = 1; i <= 3; i++) begin
            cyc(TK, 0, 0, 0, mk(0, 0, 10 - i, 1, 0, 0), "tick_10s");
        end
        cyc(TK | PS, 0, 0, 0, mk(0, 0, 6, 0, 0, 0), "tick_with_pause");
        for (int i = 0; i < 5; i++) begin
            cyc(TK, 0, 0, 0, mk(0, 0, 6, 0, 0, 0), "paused_tick");
        end
        cyc(ST, 0, 0, 0, mk(0, 0, 6, 1, 0, 0), "resume");
        cyc(TK, 0, 0, 0, mk(0, 0, 5, 1, 0, 0), "tick_after_resume");

        // Load ignored during RUN; start ignored at zero
        cyc(PS, 0, 0, 0, mk(0, 0, 5, 0, 0, 0), "pause2");
        cyc(LD, 0, 0, 7, mk(0, 0, 7, 0, 0, 0), "load_7s");
        cyc(ST, 0, 0, 0, mk(0, 0, 7, 1, 0, 0), "start_7s");
        cyc(LD | TK, 0, 30, 0, mk(0, 0, 6, 1, 0, 0), "load_in_run_tick");
        cyc(LD, 0, 30, 0, mk(0, 0, 6, 1, 0, 0), "load_in_run");
        cyc(CL, 0, 0, 0, mk(0, 0, 0, 0, 0, 0), "clear_in_run");
        cyc(ST, 0, 0, 0, mk(0, 0, 0, 0, 0, 0), "start_at_zero");

        // Expire, then reload; clear beats load
        cyc(LD, 0, 0, 1, mk(0, 0, 1, 0, 0, 0), "load_1s");
        cyc(ST, 0, 0, 0, mk(0, 0, 1, 1, 0, 0), "start_1s");
        cyc(TK, 0, 0, 0, mk(0, 0, 0, 0, 1, 1), "expire_1s");
        cyc(N, 0, 0, 0, mk(0, 0, 0, 0, 1, 0), "done_drops2");
        cyc(LD, 0, 0, 2, mk(0, 0, 2, 0, 0, 0), "load_after_expire");
        cyc(TK, 0, 0, 0, mk(0, 0, 2, 0, 0, 0), "tick_in_idle");
        cyc(CL | LD, 0, 0, 9, mk(0, 0, 0, 0, 0, 0), "clear_over_load");

        // Reset mid-run with a tick
        cyc(LD, 0, 5, 0, mk(0, 5, 0, 0, 0, 0), "load_5m");
        cyc(ST, 0, 0, 0, mk(0, 5, 0, 1, 0, 0), "start_5m");
        cyc(RS | TK, 0, 0, 0, mk(0, 0, 0, 0, 0, 0), "reset_mid_run");
        cyc(ST, 0, 0, 0, mk(0, 0, 0, 0, 0, 0), "start_after_reset");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
